// File: rtl/burst_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : burst_capture_ctrl
// Purpose  : Captures a programmable-length, optionally decimated burst of din
//            into an 8-entry buffer and provides a registered read port.
// Revision : 1.0 - initial release
// ============================================================================
module burst_capture_ctrl #(
    parameter int DW    = 4,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          abort,
    input  logic [AW:0]   len,
    input  logic [3:0]    skip,
    input  logic [DW-1:0] din,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   cnt,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_capture = 2'd1;
    localparam logic [1:0] c_done    = 2'd2;

    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [1:0]    r_state;
    logic [AW:0]   r_len;
    logic [3:0]    r_skip;
    logic [AW-1:0] r_wp;
    logic [3:0]    r_dc;
    logic [DW-1:0] r_mem [DEPTH];

    logic [AW:0]   w_len_clamped;
    logic [AW:0]   w_cnt_nxt;

    // Out-of-range lengths (0 or beyond the buffer) fall back to a full burst.
    assign w_len_clamped = ((len == '0) || (len > c_depth)) ? c_depth : len;
    assign w_cnt_nxt     = cnt + 1'b1;

    assign busy = (r_state == c_capture);
    assign done = (r_state == c_done);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= c_idle;
            r_len   <= c_depth;
            r_skip  <= '0;
            r_wp    <= '0;
            r_dc    <= '0;
            cnt     <= '0;
            rd_data <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            // Non-blocking read of the array gives read-before-write on collision.
            rd_data <= r_mem[rd_addr];
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_len   <= w_len_clamped;
                        r_skip  <= skip;
                        cnt     <= '0;
                        r_wp    <= '0;
                        r_dc    <= '0;
                        r_state <= c_capture;
                    end
                end
                c_capture: begin
                    if (abort) begin
                        r_state <= c_idle;
                    end else if (r_dc == 4'd0) begin
                        r_mem[r_wp] <= din;
                        r_wp        <= r_wp + 1'b1;
                        cnt         <= w_cnt_nxt;
                        r_dc        <= r_skip;
                        if (w_cnt_nxt == r_len) begin
                            r_state <= c_done;
                        end
                    end else begin
                        r_dc <= r_dc - 4'd1;
                    end
                end
                c_done: begin
                    r_state <= c_idle;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_burst_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_burst_capture_ctrl
// Purpose  : Directed and randomized bench for burst_capture_ctrl against a
//            schedule-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_burst_capture_ctrl;

    logic       clk;
    logic       rstn;
    logic       start;
    logic       abort;
    logic [3:0] len;
    logic [3:0] skip;
    logic [3:0] din;
    logic       busy;
    logic       done;
    logic [3:0] cnt;
    logic [2:0] rd_addr;
    logic [3:0] rd_data;

    burst_capture_ctrl #(.DW(4), .DEPTH(8), .AW(3)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .abort   (abort),
        .len     (len),
        .skip    (skip),
        .din     (din),
        .busy    (busy),
        .done    (done),
        .cnt     (cnt),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int e        = 0;

    // Reference model: writes happen at start_edge + 1 + k*(skip+1).
    logic [3:0] m_mem [8];
    bit         m_active;
    int         m_start_e;
    int         m_len;
    int         m_skip;
    int         m_cnt;
    int         m_ready;
    int         m_done_e;
    bit         din_rand;
    bit         track_wp;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, got, exp, e);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_mem[i] = 4'h0;
        m_active = 1'b0;
        m_cnt    = 0;
        m_done_e = -1;
        m_ready  = e + 1;
    endtask

    task automatic step();
        logic       s_start, s_abort;
        logic [3:0] s_len, s_skip, s_din;
        logic [2:0] s_ra;
        logic [3:0] exp_rd;
        int         n;
        s_start = start; s_abort = abort; s_len = len;
        s_skip  = skip;  s_din   = din;   s_ra  = rd_addr;
        @(posedge clk);
        e++;
        exp_rd = m_mem[s_ra];
        if (m_active) begin
            if (s_abort) begin
                m_active = 1'b0;
                m_ready  = e + 1;
            end else begin
                n = e - m_start_e;
                if (((n - 1) % (m_skip + 1)) == 0) begin
                    m_mem[m_cnt] = s_din;
                    m_cnt++;
                    if (m_cnt == m_len) begin
                        m_active = 1'b0;
                        m_done_e = e;
                        m_ready  = e + 2;
                    end
                end
            end
        end else if (e >= m_ready && s_start) begin
            m_active  = 1'b1;
            m_start_e = e;
            m_len     = (s_len == 0 || s_len > 8) ? 8 : int'(s_len);
            m_skip    = int'(s_skip);
            m_cnt     = 0;
        end
        #1;
        chk("busy", int'(busy), int'(m_active));
        chk("done", int'(done), int'(m_done_e == e));
        chk("cnt", int'(cnt), m_cnt);
        chk("rd_data", int'(rd_data), int'(exp_rd));
        din = din_rand ? 4'($urandom) : din + 4'd1;
        if (track_wp) rd_addr = 3'(m_cnt);
    endtask

    task automatic pulse_reset();
        #1 rstn = 1'b0;
        #1;
        model_reset();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cnt", int'(cnt), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        #2 rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; abort = 1'b0; len = 4'd0; skip = 4'd0;
        din = 4'd0; rd_addr = 3'd0; din_rand = 1'b0; track_wp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("por_busy", int'(busy), 0);
        chk("por_cnt", int'(cnt), 0);
        chk("por_rd_data", int'(rd_data), 0);
        #1 rstn = 1'b1;

        // Reset contents readout
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            step();
            chk("rst_mem", int'(rd_data), 0);
        end

        // Full burst, len=0 clamps to 8, din 3..A
        din = 4'd2; len = 4'd0; skip = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (8) step();
        chk("full_done_t9", int'(done), 1);
        chk("full_cnt", int'(cnt), 8);
        step();
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            step();
            chk("full_mem", int'(rd_data), (3 + i) & 15);
        end

        // Decimated partial burst with rd_addr following the write pointer
        len = 4'd3; skip = 4'd2; start = 1'b1; track_wp = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        chk("dec_cnt", int'(cnt), 3);
        track_wp = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            step();
        end

        // Abort on the 5th write edge, then immediate restart
        len = 4'd8; skip = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_cnt", int'(cnt), 4);
        chk("abort_busy", int'(busy), 0);
        start = 1'b1; len = 4'd2;
        step();
        start = 1'b0;
        chk("restart_busy", int'(busy), 1);
        repeat (4) step();

        // Starts during capture are ignored; reset mid-burst
        len = 4'd8; skip = 4'd1; start = 1'b1;
        step();
        repeat (3) begin
            step();
            start = ~start;
        end
        start = 1'b0;
        step();
        pulse_reset();
        repeat (20) step();
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            step();
        end

        // Randomized traffic
        din_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            start   = ($urandom_range(0, 3) == 0);
            abort   = ($urandom_range(0, 19) == 0);
            len     = 4'($urandom);
            skip    = 4'($urandom_range(0, 3));
            rd_addr = 3'($urandom);
            if ($urandom_range(0, 2) == 0) rd_addr = 3'(m_cnt);
            step();
            if (i == 200) pulse_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/burst_capture_ctrl.md
# burst_capture_ctrl

Sequencer for the team's 8-entry sample buffer. On a start pulse it captures a programmable-length burst of a free-running data input into the buffer, optionally decimated. It reports completion with a one-cycle done pulse and exposes a registered read port for post-capture readout. It sits between the stimulus/counter source and any consumer that needs a snapshot of consecutive samples.

## Interface
- DW, 4, sample width in bits
- DEPTH, 8, buffer entries (power of two)
- AW, 3, address width, log2(DEPTH)

- clk  in  1  clock; all logic on posedge
- rstn  in  1  asynchronous, active-low reset
- start  in  1  capture request; sampled only in IDLE
- abort  in  1  terminates an active capture
- len  in  AW+1  burst length; 1..DEPTH valid; 0 or >DEPTH treated as DEPTH
- skip  in  4  decimation; capture every skip+1 cycles
- din  in  DW  sample input
- busy  out  1  high in CAPTURE
- done  out  1  one-cycle pulse on normal completion
- cnt  out  AW+1  samples written in the current/last burst
- rd_addr  in  AW  read address
- rd_data  out  DW  registered read data

## Operation
- States: IDLE, CAPTURE, DONE (encoded registers; no other states).
- IDLE: when start=1, latch len_q (0 or >DEPTH clamped to DEPTH) and skip_q. Clear cnt, write pointer wp and decimation counter dc. Go to CAPTURE. Otherwise stay in IDLE.
- CAPTURE:
  - When dc==0: buf[wp] <= din, wp++, cnt++, dc <= skip_q.
  - When dc!=0: dc--.
  - When the write makes cnt==len_q: go to DONE.
- DONE: done=1 for exactly this cycle, then IDLE.
- start outside IDLE is ignored; it is neither queued nor latched. len/skip changes outside IDLE have no effect.
- abort in CAPTURE goes to IDLE on the same edge with no write on that edge and no done pulse; cnt holds the samples written so far. abort in IDLE or DONE is ignored. If abort and the final write coincide, abort wins: no write, no done.
- Buffer entries not written in a burst keep their previous contents.
- wp is AW bits and wraps naturally; it cannot exceed DEPTH-1 because len_q<=DEPTH.
- Read port: rd_data <= buf[rd_addr] every cycle in any state. A same-edge write to the same address returns the old data (read-before-write).
- Reset (asynchronous, any state, including mid-burst):
  - State returns to IDLE.
  - busy=0, done=0, cnt=0, rd_data=0.
  - All buffer entries=0; wp=0, dc=0, len_q=DEPTH, skip_q=0.

## Timing
- start high at edge T: CAPTURE from T. The first sample is written at edge T+1 (din as presented before T+1).
- Sample k (0-based) is written at edge T+1+k*(skip+1).
- The last write is at edge T+1+(len-1)*(skip+1). done is high during the following cycle. State is IDLE one cycle after that, when a new start is accepted.
- busy rises at T and falls at the last-write edge.
- Back-to-back bursts: minimum start-to-start spacing is (len-1)*(skip+1)+3 cycles.
- rd_data latency: 1 cycle from rd_addr.
- cnt updates on the same edge as each write.

## Test plan
- Reset then idle: after rstn release, all reads of addresses 0..7 give 0; busy=0, done=0, cnt=0.
- Full burst: din increments by 1 each cycle, starting at 4'h3 at the first write edge; start with len=0, skip=0. Required: done exactly 9 cycles after start (edges T+1..T+8 write, done in the T+9 cycle); buf = 3,4,5,6,7,8,9,A; cnt=8.
- Decimated partial burst: same din, len=3, skip=2. Required: writes at T+1, T+4, T+7 storing x, x+3, x+6 in addresses 0..2; addresses 3..7 unchanged; cnt=3.
- Abort: len=8, skip=0, abort asserted at the 5th write edge. Required: 4 entries written, 5th entry unchanged, no done pulse, cnt=4, busy low next cycle; start accepted next cycle.
- Ignored start and reset mid-burst: start pulses during CAPTURE do not restart the burst. rstn low for 3 ns mid-burst clears buffer/cnt/busy immediately; no done follows.
- Read collision: during a burst, rd_addr equal to the current wp returns the pre-write value that cycle and the new sample one cycle later.
